// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
//
// Receive buffer sitting directly behind uart_rx. Every byte uart_rx offers is
// stored with its parity and frame error flags in a DEPTH-entry
// first-word-fall-through FIFO. A UART line cannot be back-pressured, so the
// buffer never stalls the receiver. Bytes that arrive while the FIFO is full
// are dropped and counted. When DROP_FRAME_ERR is set, bytes with a stop-bit
// error are discarded on arrival and are also counted.
//
// Parameters
//   DEPTH           number of entries (power of two, >= 2)
//   ADDR_W          log2(DEPTH)
//   DROP_FRAME_ERR  1: discard bytes whose s_frame_err is set
//
// Ports
//   clk            system clock
//   reset_n        asynchronous reset, active-low
//   s_valid        byte valid from uart_rx
//   s_ready        ready to uart_rx; 0 in reset, 1 from the first edge after
//   s_data         received byte
//   s_parity_err   parity error flag for s_data
//   s_frame_err    stop-bit error flag for s_data
//   m_valid        head entry valid (FIFO not empty)
//   m_ready        consumer pops the head when m_valid && m_ready
//   m_data         head byte
//   m_parity_err   head parity flag
//   m_frame_err    head frame flag
//   count          entries stored, 0..DEPTH
//   full           count == DEPTH
//   empty          count == 0
//   overflow       sticky: a byte was lost because the FIFO was full
//   drop_cnt       bytes dropped (full or discarded), saturating at 255
//   clr_overflow   one-cycle pulse clearing overflow and drop_cnt
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
   parameter int DEPTH          = 16,
   parameter int ADDR_W         = 4,
   parameter bit DROP_FRAME_ERR = 1'b0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [7:0]        s_data,
   input  logic              s_parity_err,
   input  logic              s_frame_err,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [7:0]        m_data,
   output logic              m_parity_err,
   output logic              m_frame_err,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              empty,
   output logic              overflow,
   output logic [7:0]        drop_cnt,
   input  logic              clr_overflow
);

   localparam logic [ADDR_W:0]   DEPTH_C   = DEPTH[ADDR_W:0];
   localparam logic [ADDR_W:0]   CNT_ZERO_C = '0;
   localparam logic [ADDR_W:0]   CNT_ONE_C  = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] PTR_ZERO_C = '0;
   localparam logic [ADDR_W-1:0] PTR_ONE_C  = {{(ADDR_W-1){1'b0}}, 1'b1};

   // Saturating increment for the drop counter: parks at 255, never wraps.
   function automatic logic [7:0] sat_inc8(input logic [7:0] value);
      logic [7:0] result;
      if (value == 8'hFF) begin
         result = value;
      end else begin
         result = value + 8'd1;
      end
      return result;
   endfunction

   // Entry layout: {frame_err, parity_err, data}
   logic [9:0]        mem_r [DEPTH];

   logic [ADDR_W-1:0] wr_ptr_r;
   logic [ADDR_W-1:0] rd_ptr_r;
   logic [ADDR_W:0]   count_r;
   logic              full_r;
   logic              empty_r;
   logic              overflow_r;
   logic [7:0]        drop_cnt_r;
   logic              s_ready_r;

   logic              offer_s;
   logic              discard_s;
   logic              push_s;
   logic              pop_s;
   logic              push_acc_s;
   logic              drop_full_s;
   logic              drop_any_s;

   logic [ADDR_W-1:0] wr_ptr_nxt_s;
   logic [ADDR_W-1:0] rd_ptr_nxt_s;
   logic [ADDR_W:0]   count_nxt_s;
   logic              overflow_nxt_s;
   logic [7:0]        drop_cnt_nxt_s;
   logic [7:0]        drop_base_s;
   logic              overflow_base_s;
   logic [9:0]        head_s;

   // Handshake decode: which byte is accepted, popped or dropped this cycle.
   always_comb begin
      offer_s     = s_valid && s_ready_r;
      discard_s   = DROP_FRAME_ERR && s_frame_err;
      push_s      = offer_s && !discard_s;
      pop_s       = !empty_r && m_ready;
      // A full FIFO still accepts when the head leaves in the same cycle.
      push_acc_s  = push_s && (!full_r || pop_s);
      drop_full_s = push_s && !push_acc_s;
      drop_any_s  = drop_full_s || (offer_s && discard_s);
   end

   // Next-state for pointers, occupancy and drop bookkeeping.
   always_comb begin
      wr_ptr_nxt_s    = wr_ptr_r;
      rd_ptr_nxt_s    = rd_ptr_r;
      count_nxt_s     = count_r;
      overflow_nxt_s  = overflow_r;
      drop_cnt_nxt_s  = drop_cnt_r;
      drop_base_s     = drop_cnt_r;
      overflow_base_s = overflow_r;

      if (push_acc_s) begin
         wr_ptr_nxt_s = wr_ptr_r + PTR_ONE_C;
      end else begin
         wr_ptr_nxt_s = wr_ptr_r;
      end

      if (pop_s) begin
         rd_ptr_nxt_s = rd_ptr_r + PTR_ONE_C;
      end else begin
         rd_ptr_nxt_s = rd_ptr_r;
      end

      case ({push_acc_s, pop_s})
         2'b10:   count_nxt_s = count_r + CNT_ONE_C;
         2'b01:   count_nxt_s = count_r - CNT_ONE_C;
         default: count_nxt_s = count_r;
      endcase

      // Clear is applied first, so a drop in the same cycle still lands.
      if (clr_overflow) begin
         drop_base_s     = 8'd0;
         overflow_base_s = 1'b0;
      end else begin
         drop_base_s     = drop_cnt_r;
         overflow_base_s = overflow_r;
      end

      if (drop_any_s) begin
         drop_cnt_nxt_s = sat_inc8(drop_base_s);
      end else begin
         drop_cnt_nxt_s = drop_base_s;
      end

      // Only full-FIFO losses are overflow; discarded frame errors are not.
      if (drop_full_s) begin
         overflow_nxt_s = 1'b1;
      end else begin
         overflow_nxt_s = overflow_base_s;
      end
   end

   // Pointer, occupancy, status and drop registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_r   <= PTR_ZERO_C;
         rd_ptr_r   <= PTR_ZERO_C;
         count_r    <= CNT_ZERO_C;
         full_r     <= 1'b0;
         empty_r    <= 1'b1;
         overflow_r <= 1'b0;
         drop_cnt_r <= 8'd0;
         s_ready_r  <= 1'b0;
      end else begin
         wr_ptr_r   <= wr_ptr_nxt_s;
         rd_ptr_r   <= rd_ptr_nxt_s;
         count_r    <= count_nxt_s;
         full_r     <= (count_nxt_s == DEPTH_C);
         empty_r    <= (count_nxt_s == CNT_ZERO_C);
         overflow_r <= overflow_nxt_s;
         drop_cnt_r <= drop_cnt_nxt_s;
         s_ready_r  <= 1'b1;
      end
   end

   // Storage array; contents are not reset, only pointers are.
   always_ff @(posedge clk) begin
      if (push_acc_s) begin
         mem_r[wr_ptr_r] <= {s_frame_err, s_parity_err, s_data};
      end
   end

   // First-word-fall-through head: read straight from the read pointer.
   always_comb begin
      head_s = mem_r[rd_ptr_r];
   end

   assign s_ready      = s_ready_r;
   assign m_valid      = !empty_r;
   assign m_data       = head_s[7:0];
   assign m_parity_err = head_s[8];
   assign m_frame_err  = head_s[9];
   assign count        = count_r;
   assign full         = full_r;
   assign empty        = empty_r;
   assign overflow     = overflow_r;
   assign drop_cnt     = drop_cnt_r;

endmodule
